// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue_if                                                             |
// | Memory handshake plus core-facing head/consume/redirect bundle.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic               o_DataReq;
  logic [XLEN-1:0]    o_MemAddr;
  logic               i_MemReady;
  logic [XLEN-1:0]    i_DataBlock;
  logic               o_valid;
  logic [XLEN-1:0]    o_instr;
  logic [XLEN-1:0]    o_pc;
  logic               i_next;
  logic               i_redirect;
  logic [XLEN-1:0]    i_redirect_pc;
  logic [c_CNT_W-1:0] o_count;

  modport master (
    output o_DataReq, o_MemAddr,
    input  i_MemReady, i_DataBlock,
    output o_valid, o_instr, o_pc,
    input  i_next, i_redirect, i_redirect_pc,
    output o_count
  );

  modport slave (
    input  o_DataReq, o_MemAddr,
    output i_MemReady, i_DataBlock,
    input  o_valid, o_instr, o_pc,
    output i_next, i_redirect, i_redirect_pc,
    input  o_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif
// +----------------------------------------------------------------------------+
// | fetch_queue                                                                |
// | Sequential instruction fetch with a DEPTH-entry {instr, pc} queue.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = `PC_RESET
) (
  input logic           i_clk,
  input logic           i_rst,
  fetch_queue_if.master bus
);
  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [XLEN-1:0]    c_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_fpc;
  logic [XLEN-1:0]    r_addr;
  logic               r_req;
  logic               r_valid;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [XLEN-1:0]    r_instr_q [DEPTH];
  logic [XLEN-1:0]    r_pc_q    [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic               w_space;
  logic [c_CNT_W-1:0] w_count_next;
  logic [XLEN-1:0]    w_redirect_pc;
  logic [XLEN-1:0]    w_fpc_inc;

  // A redirect cancels both queue operations of its cycle.
  always_comb begin
    w_pop         = bus.i_next & r_valid & ~bus.i_redirect;
    w_push        = (r_state == S_REQ) & bus.i_MemReady & ~bus.i_redirect;
    w_count_next  = bus.i_redirect ? '0
                  : r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    w_space       = (w_count_next < c_DEPTH);
    w_redirect_pc = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
    w_fpc_inc     = r_fpc + c_STEP;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else begin
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      if (bus.i_redirect) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_instr_q[r_tail] <= bus.i_DataBlock;
          r_pc_q[r_tail]    <= r_fpc;
          r_tail            <= r_tail + c_PTR_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_ONE;
        end
      end
    end
  end

  // Only REQ may push; it is entered only with a free slot, so no overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_fpc   <= PC_RESET;
      r_addr  <= PC_RESET;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_redirect) begin
            r_fpc   <= w_redirect_pc;
            r_addr  <= w_redirect_pc;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (w_space) begin
            r_addr  <= r_fpc;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.i_redirect) begin
            r_fpc <= w_redirect_pc;
            if (bus.i_MemReady) begin
              r_addr <= w_redirect_pc;
            end else begin
              r_state <= S_DROP;
            end
          end else if (bus.i_MemReady) begin
            r_fpc  <= w_fpc_inc;
            r_addr <= w_fpc_inc;
            if (!w_space) begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          // Address stays on the stale request until its response retires it.
          if (bus.i_redirect) begin
            r_fpc <= w_redirect_pc;
          end
          if (bus.i_MemReady) begin
            r_addr  <= bus.i_redirect ? w_redirect_pc : r_fpc;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_DataReq = r_req;
  assign bus.o_MemAddr = r_addr;
  assign bus.o_valid   = r_valid;
  assign bus.o_count   = r_count;
  assign bus.o_instr   = r_instr_q[r_head];
  assign bus.o_pc      = r_pc_q[r_head];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue                                                             |
// | Directed bench: two instances (PC_RESET 0 and 0xFFFF_FFF8), modelled mem.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   nvec  = 0;
  int   nfail = 0;
  int   lat   = 0;
  int   cnt0  = 0;
  bit   auto0 = 1'b1;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus0 ();
  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus1 ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0000_0000)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'hFFFF_FFF8)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock, then the memory models answer for the cycle just entered (word = address).
  task automatic step();
    @(posedge clk);
    #1;
    if (auto0) begin
      if (bus0.o_DataReq === 1'b1) begin
        if (cnt0 >= lat) begin
          bus0.i_MemReady  = 1'b1;
          bus0.i_DataBlock = bus0.o_MemAddr;
          cnt0 = 0;
        end else begin
          bus0.i_MemReady = 1'b0;
          cnt0++;
        end
      end else begin
        bus0.i_MemReady = 1'b0;
        cnt0 = 0;
      end
    end
    bus1.i_MemReady  = (bus1.o_DataReq === 1'b1);
    bus1.i_DataBlock = bus1.o_MemAddr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.i_next = 1'b0;
    bus0.i_redirect = 1'b0;
    cnt0 = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus0.o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit seen_valid;
    bit found;
    rst = 1'b1;
    bus0.i_MemReady = 1'b0; bus0.i_DataBlock = '0;
    bus0.i_next = 1'b0; bus0.i_redirect = 1'b0; bus0.i_redirect_pc = '0;
    bus1.i_MemReady = 1'b0; bus1.i_DataBlock = '0;
    bus1.i_next = 1'b0; bus1.i_redirect = 1'b0; bus1.i_redirect_pc = '0;

    // Reset values and zero-wait streaming
    step();
    step();
    chk("rst_req",   32'(bus0.o_DataReq), 32'd0);
    chk("rst_addr",  bus0.o_MemAddr,      32'h0);
    chk("rst_valid", 32'(bus0.o_valid),   32'd0);
    chk("rst_count", 32'(bus0.o_count),   32'd0);
    chk("rst_instr", bus0.o_instr,        32'h0);
    chk("rst_pc",    bus0.o_pc,           32'h0);
    chk("rst_addr1", bus1.o_MemAddr,      32'hFFFF_FFF8);
    rst = 1'b0;
    chk("cyc1_idle", 32'(bus0.o_DataReq), 32'd0);
    bus0.i_next = 1'b1;
    step();
    chk("cyc2_req",  32'(bus0.o_DataReq), 32'd1);
    chk("cyc2_addr", bus0.o_MemAddr,      32'h0);
    chk("wrap_a0",   bus1.o_MemAddr,      32'hFFFF_FFF8);
    step();
    chk("s_pc0",     bus0.o_pc,           32'h0);
    chk("s_in0",     bus0.o_instr,        32'h0);
    chk("s_v0",      32'(bus0.o_valid),   32'd1);
    chk("wrap_a1",   bus1.o_MemAddr,      32'hFFFF_FFFC);
    step();
    chk("s_pc4",     bus0.o_pc,           32'h4);
    chk("s_in4",     bus0.o_instr,        32'h4);
    chk("wrap_a2",   bus1.o_MemAddr,      32'h0);
    step();
    chk("s_pc8",     bus0.o_pc,           32'h8);
    chk("s_in8",     bus0.o_instr,        32'h8);

    // Fill with no consumption, then a single pop
    do_reset();
    repeat (5) step();
    chk("full_count", 32'(bus0.o_count),   32'd4);
    chk("full_req",   32'(bus0.o_DataReq), 32'd0);
    repeat (3) step();
    chk("full_count2", 32'(bus0.o_count),   32'd4);
    chk("full_req2",   32'(bus0.o_DataReq), 32'd0);
    bus0.i_next = 1'b1;
    step();
    bus0.i_next = 1'b0;
    chk("pop1_req",   32'(bus0.o_DataReq), 32'd1);
    chk("pop1_addr",  bus0.o_MemAddr,      32'h10);
    chk("pop1_count", 32'(bus0.o_count),   32'd3);
    chk("pop1_head",  bus0.o_pc,           32'h4);
    step();
    chk("refill_count", 32'(bus0.o_count),   32'd4);
    chk("refill_req",   32'(bus0.o_DataReq), 32'd0);
    repeat (2) step();
    chk("refill_req2",  32'(bus0.o_DataReq), 32'd0);

    // Redirect during a 3-cycle-latency request
    lat = 3;
    do_reset();
    bus0.i_next = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus0.o_DataReq === 1'b1 && bus0.o_MemAddr === 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    chk("lat_req8_seen", 32'(found), 32'd1);
    step();
    bus0.i_redirect = 1'b1;
    bus0.i_redirect_pc = 32'h103;
    step();
    bus0.i_redirect = 1'b0;
    chk("rd_valid", 32'(bus0.o_valid),   32'd0);
    chk("rd_req",   32'(bus0.o_DataReq), 32'd1);
    chk("rd_stale", bus0.o_MemAddr,      32'h8);
    seen_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus0.o_valid !== 1'b0) seen_valid = 1'b1;
      if (bus0.o_MemAddr !== 32'h8) break;
    end
    chk("drop_no_head", 32'(seen_valid), 32'd0);
    chk("drop_newaddr", bus0.o_MemAddr,  32'h100);
    wait_valid("rd_wait");
    chk("rd_head_pc", bus0.o_pc,    32'h100);
    chk("rd_head_in", bus0.o_instr, 32'h100);

    // Redirect coinciding with response and pop at count=2
    lat = 0;
    do_reset();
    repeat (3) step();
    chk("c2_count", 32'(bus0.o_count), 32'd2);
    auto0 = 1'b0;
    bus0.i_MemReady = 1'b1;
    bus0.i_DataBlock = 32'h8;
    bus0.i_next = 1'b1;
    bus0.i_redirect = 1'b1;
    bus0.i_redirect_pc = 32'h200;
    step();
    bus0.i_MemReady = 1'b0;
    bus0.i_next = 1'b0;
    bus0.i_redirect = 1'b0;
    chk("co_count", 32'(bus0.o_count),   32'd0);
    chk("co_valid", 32'(bus0.o_valid),   32'd0);
    chk("co_req",   32'(bus0.o_DataReq), 32'd1);
    chk("co_addr",  bus0.o_MemAddr,      32'h200);
    step();
    chk("co_count2", 32'(bus0.o_count), 32'd0);
    auto0 = 1'b1;
    wait_valid("co_wait");
    chk("co_head_pc", bus0.o_pc, 32'h200);

    // Reset mid-request, late response right after release
    lat = 3;
    do_reset();
    step();
    chk("mr_req", 32'(bus0.o_DataReq), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("mr_drop", 32'(bus0.o_DataReq), 32'd0);
    rst = 1'b0;
    auto0 = 1'b0;
    bus0.i_MemReady = 1'b1;
    bus0.i_DataBlock = 32'hDEAD_BEEF;
    step();
    bus0.i_MemReady = 1'b0;
    chk("late_count", 32'(bus0.o_count),   32'd0);
    chk("late_valid", 32'(bus0.o_valid),   32'd0);
    chk("late_req",   32'(bus0.o_DataReq), 32'd1);
    chk("late_addr",  bus0.o_MemAddr,      32'h0);
    lat = 0;
    cnt0 = 0;
    auto0 = 1'b1;
    wait_valid("late_wait");
    chk("late_head_pc", bus0.o_pc,    32'h0);
    chk("late_head_in", bus0.o_instr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: owns the fetch PC, issues sequential word requests over the existing `DataReq`/`MemReady` instruction-memory handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It replaces the fixed PC register plus single-instruction fetch of the single-cycle datapath. The core can consume one instruction per cycle without waiting on memory latency. Taken branches, jumps, traps and xRET reach it as a redirect, which flushes the queue and any in-flight response.

## Interface
- `PC_RESET`, default `` `PC_RESET ``: fetch PC after reset.
- `XLEN`, default 32: address and instruction width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `o_DataReq`  out  1  fetch request, held until accepted.
- `o_MemAddr`  out  XLEN  word address of the request; stable while `o_DataReq`=1.
- `i_MemReady`  in  1  one-cycle pulse: `i_DataBlock` valid, request complete.
- `i_DataBlock`  in  XLEN  returned instruction word.
- `o_valid`  out  1  head entry valid.
- `o_instr`  out  XLEN  head instruction.
- `o_pc`  out  XLEN  PC of head instruction.
- `i_next`  in  1  consume head this cycle; ignored when `o_valid`=0.
- `i_redirect`  in  1  flush and restart fetch.
- `i_redirect_pc`  in  XLEN  new fetch PC; bits [1:0] forced to 0.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: `fpc` (next address to fetch), FIFO (head/tail pointers, count), FSM {IDLE, REQ, DROP}. Only one request is outstanding at a time.
- IDLE: if count_next < DEPTH, go to REQ next cycle with `o_MemAddr`=`fpc`. Otherwise stay.
- REQ: `o_DataReq`=1. On `i_MemReady`:
  - push {`i_DataBlock`, `fpc`} at tail; `fpc` += 4, modulo 2^XLEN, wrapping silently.
  - stay in REQ with the new address if count_next < DEPTH, else go to IDLE.
  - A slot is reserved while in REQ: count cannot grow, so the push never overflows.
- DROP: `o_DataReq`=1 at the stale address. On `i_MemReady`, discard data and go to REQ at `fpc`.
- count_next = count + push − pop. Pop = `i_next` & `o_valid` & !`i_redirect`.
- Redirect behaviour, in any state:
  - count, head and tail go to 0; `fpc` takes `i_redirect_pc` with bits [1:0] cleared; any push or pop that cycle is cancelled.
  - REQ without `i_MemReady` goes to DROP.
  - REQ with `i_MemReady` discards the data and goes to REQ at the new PC.
  - IDLE goes to REQ.
  - DROP stays DROP; only `fpc` is updated.
- `o_valid` = (count≠0). `o_instr` and `o_pc` are the head entry read combinationally from registers, with no memory-to-output path.
- `i_MemReady` in IDLE is ignored, covering late responses after reset.

## Timing
- Reset values: `o_DataReq`=0, `o_MemAddr`=`PC_RESET`, `o_valid`=0, `o_count`=0, `o_instr`=0, `o_pc`=0. FSM=IDLE, `fpc`=`PC_RESET`.
- First cycle after `i_rst` falls: IDLE. Second cycle: `o_DataReq`=1.
- All outputs except `o_instr`/`o_pc` are registered.
- Latency: data returned with `i_MemReady` in cycle N appears at head (`o_valid`=1, if the queue was empty) in cycle N+1.
- Back-to-back: a new request is issued at N+1 when space exists, so a zero-wait memory sustains 1 instr per cycle.
- Redirect at N: `o_valid`=0 at N+1. New-PC request is visible at N+1 from IDLE or REQ, or after the stale response from DROP.
- Full plus pop in the same cycle as a response: legal, count unchanged.
- `i_rst` mid-request: `o_DataReq` drops next cycle. The memory side is reset by the same signal.

## Test plan
- Reset, `PC_RESET`=0x0, memory with 0-wait, words = address: `o_DataReq` high at cycle 2. Instructions 0x0, 0x4, 0x8 appear consecutively with matching `o_pc`, one per cycle while `i_next`=1.
- `i_next`=0, DEPTH=4: exactly 4 pushes. `o_count`=4, `o_DataReq`=0 and stays 0. A single `i_next` causes exactly one new request, at address 0x10.
- 3-cycle memory latency, redirect to 0x103 one cycle after request 0x8: `o_DataReq` stays high for the 0x8 response, which is dropped and never reaches the head. The next request is address 0x100. First valid head is `o_pc`=0x100.
- Redirect coinciding with `i_MemReady` and `i_next` with count=2: count=0 next cycle, response discarded, request 0x200 issued next cycle.
- `PC_RESET`=0xFFFF_FFF8: fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 in order.
- `i_rst` asserted during outstanding request, late `i_MemReady` one cycle after release: ignored, `o_count`=0, fetch restarts at `PC_RESET`.
